// File: rtl/psr_writeback_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psr_writeback_stage_pkg
//  Description : Shared definitions for the ALU writeback stage and the
//                branch unit: PSR bit positions, condition-code encodings,
//                per-opcode flag-update masks and the masked PSR merge.
//  Revision    : 1.0 - initial release
// ============================================================================
package psr_writeback_stage_pkg;

    // PSR layout, LSB first: C F L Z N
    localparam int PSR_W = 5;
    localparam int PSR_C = 0;
    localparam int PSR_F = 1;
    localparam int PSR_L = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    // Branch condition selectors
    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_HI = 4'h4,
        COND_LS = 4'h5,
        COND_GT = 4'h6,
        COND_LE = 4'h7,
        COND_FS = 4'h8,
        COND_FC = 4'h9,
        COND_LO = 4'hA,
        COND_HS = 4'hB,
        COND_LT = 4'hC,
        COND_GE = 4'hD,
        COND_UC = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Flags written by each opcode class; flags outside the mask keep
    // their previous architectural value.
    localparam logic [PSR_W-1:0] FMASK_ADD   = (5'b1 << PSR_C) | (5'b1 << PSR_F);
    localparam logic [PSR_W-1:0] FMASK_SUB   = (5'b1 << PSR_C) | (5'b1 << PSR_F)
                                             | (5'b1 << PSR_L);
    localparam logic [PSR_W-1:0] FMASK_CMP   = (5'b1 << PSR_Z) | (5'b1 << PSR_N)
                                             | (5'b1 << PSR_L);
    localparam logic [PSR_W-1:0] FMASK_LOGIC = 5'b00000;

    // Replace only the masked flags of the old PSR with the new ones.
    function automatic logic [PSR_W-1:0] psr_merge(
        input logic [PSR_W-1:0] old_psr,
        input logic [PSR_W-1:0] new_flags,
        input logic [PSR_W-1:0] mask
    );
        return (old_psr & ~mask) | (new_flags & mask);
    endfunction

endpackage : psr_writeback_stage_pkg
`default_nettype wire

// File: rtl/psr_writeback_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : psr_writeback_stage_if
//  Description : Signal bundle around the writeback stage.
//                  in_*      : ALU -> stage valid/ready input
//                  out_*     : stage -> register-file write port
//                  psr_wr_*  : explicit PSR load (LPR)
//                  psr       : architectural PSR
//                  cond_*    : branch condition query
//                master = surrounding pipeline/controller, slave = stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface psr_writeback_stage_if #(
    parameter int WIDTH   = 16,
    parameter int REGADDR = 4
);
    import psr_writeback_stage_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_result;
    logic [PSR_W-1:0]     in_psr;
    logic [PSR_W-1:0]     in_flag_mask;
    logic [REGADDR-1:0]   in_dest;
    logic                 in_wb_en;

    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_result;
    logic [REGADDR-1:0]   out_dest;
    logic                 out_wb_en;

    logic                 psr_wr_en;
    logic [PSR_W-1:0]     psr_wr_data;
    logic [PSR_W-1:0]     psr;

    logic [3:0]           cond_code;
    logic                 cond_true;

    modport master (
        output in_valid, in_result, in_psr, in_flag_mask, in_dest, in_wb_en,
        input  in_ready,
        input  out_valid, out_result, out_dest, out_wb_en,
        output out_ready,
        output psr_wr_en, psr_wr_data,
        input  psr,
        output cond_code,
        input  cond_true
    );

    modport slave (
        input  in_valid, in_result, in_psr, in_flag_mask, in_dest, in_wb_en,
        output in_ready,
        output out_valid, out_result, out_dest, out_wb_en,
        input  out_ready,
        input  psr_wr_en, psr_wr_data,
        output psr,
        input  cond_code,
        output cond_true
    );

endinterface : psr_writeback_stage_if
`default_nettype wire

// File: rtl/psr_writeback_stage_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : psr_writeback_stage_cond_eval
//  Description : Purely combinational branch condition decoder.
//  Ports       : i_psr       - PSR {N,Z,L,F,C}
//                i_cond_code - 4-bit condition selector
//                o_cond_true - condition holds for i_psr
//  Revision    : 1.0 - initial release
// ============================================================================
module psr_writeback_stage_cond_eval
    import psr_writeback_stage_pkg::*;
(
    input  wire logic [PSR_W-1:0] i_psr,
    input  wire logic [3:0]       i_cond_code,
    output logic                  o_cond_true
);

    logic w_c;
    logic w_f;
    logic w_l;
    logic w_z;
    logic w_n;

    assign w_c = i_psr[PSR_C];
    assign w_f = i_psr[PSR_F];
    assign w_l = i_psr[PSR_L];
    assign w_z = i_psr[PSR_Z];
    assign w_n = i_psr[PSR_N];

    always_comb begin
        o_cond_true = 1'b0;
        case (cond_e'(i_cond_code))
            COND_EQ: o_cond_true = w_z;
            COND_NE: o_cond_true = !w_z;
            COND_CS: o_cond_true = w_c;
            COND_CC: o_cond_true = !w_c;
            COND_HI: o_cond_true = w_l;
            COND_LS: o_cond_true = !w_l;
            COND_GT: o_cond_true = w_n;
            COND_LE: o_cond_true = !w_n;
            COND_FS: o_cond_true = w_f;
            COND_FC: o_cond_true = !w_f;
            COND_LO: o_cond_true = !w_l && !w_z;
            COND_HS: o_cond_true = w_l || w_z;
            COND_LT: o_cond_true = !w_n && !w_z;
            COND_GE: o_cond_true = w_n || w_z;
            COND_UC: o_cond_true = 1'b1;
            COND_NV: o_cond_true = 1'b0;
            default: o_cond_true = 1'b0;
        endcase
    end

endmodule : psr_writeback_stage_cond_eval
`default_nettype wire

// File: rtl/psr_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : psr_writeback_stage
//  Description : Writeback stage after the 16-bit ALU. Holds one result
//                entry behind a valid/ready handshake, maintains the
//                architectural PSR with per-instruction flag masks and
//                answers branch condition queries against the committed PSR.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-high reset
//                bus   - psr_writeback_stage_if.slave (handshake, PSR,
//                        explicit PSR load, condition query)
//  Revision    : 1.0 - initial release
// ============================================================================
module psr_writeback_stage
    import psr_writeback_stage_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGADDR = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    psr_writeback_stage_if.slave   bus
);

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_result;
    logic [REGADDR-1:0]   r_out_dest;
    logic                 r_out_wb_en;
    logic [PSR_W-1:0]     r_psr;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_drain;
    logic [PSR_W-1:0]     w_psr_merged;

    // Ready depends only on the registered valid and the downstream ready,
    // so there is never a path from in_valid back to in_ready.
    assign w_in_ready   = !r_out_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_drain      = r_out_valid && bus.out_ready;
    assign w_psr_merged = psr_merge(r_psr, bus.in_psr, bus.in_flag_mask);

    // Output entry register. Data fields are only loaded on accept so that
    // in_* values presented with in_valid=0 never propagate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_dest   <= '0;
            r_out_wb_en  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_out_result <= bus.in_result;
                r_out_dest   <= bus.in_dest;
                r_out_wb_en  <= bus.in_wb_en;
            end else if (w_drain) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    // Architectural PSR. An explicit load overrides a masked update
    // arriving in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_psr <= '0;
        end else if (bus.psr_wr_en) begin
            r_psr <= bus.psr_wr_data;
        end else if (w_accept) begin
            r_psr <= w_psr_merged;
        end
    end

    // Conditions use the committed PSR, so a branch in the same cycle as a
    // flag-setting accept still sees the old flags.
    psr_writeback_stage_cond_eval u_cond_eval (
        .i_psr       (r_psr),
        .i_cond_code (bus.cond_code),
        .o_cond_true (bus.cond_true)
    );

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_dest   = r_out_dest;
    assign bus.out_wb_en  = r_out_wb_en;
    assign bus.psr        = r_psr;

endmodule : psr_writeback_stage
`default_nettype wire

// File: tb/tb_psr_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psr_writeback_stage
//  Description : Directed self-checking bench for psr_writeback_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psr_writeback_stage;

    localparam int c_WIDTH   = 16;
    localparam int c_REGADDR = 4;

    logic clk;
    logic reset;

    int r_tests;
    int r_fails;

    psr_writeback_stage_if #(.WIDTH(c_WIDTH), .REGADDR(c_REGADDR)) bus ();

    psr_writeback_stage #(.WIDTH(c_WIDTH), .REGADDR(c_REGADDR)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_tests++;
        if (got !== exp) begin
            r_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_psr(input logic [4:0] v);
        bus.psr_wr_en   = 1'b1;
        bus.psr_wr_data = v;
        step();
        bus.psr_wr_en   = 1'b0;
    endtask

    task automatic drive_in(input logic v, input logic [15:0] res, input logic [3:0] dst,
                            input logic [4:0] flags, input logic [4:0] mask);
        bus.in_valid     = v;
        bus.in_result    = res;
        bus.in_dest      = dst;
        bus.in_wb_en     = v;
        bus.in_psr       = flags;
        bus.in_flag_mask = mask;
    endtask

    logic [4:0]  sweep_psr [4];
    logic [15:0] sweep_exp [4];
    logic [15:0] exp_vec;

    initial begin
        r_tests = 0;
        r_fails = 0;
        reset   = 1'b1;
        bus.out_ready   = 1'b1;
        bus.psr_wr_en   = 1'b0;
        bus.psr_wr_data = 5'b0;
        bus.cond_code   = 4'h0;
        drive_in(1'b0, 16'h0, 4'h0, 5'h0, 5'h0);

        // Bit i of each expected vector is cond_true for cond_code i.
        sweep_psr[0] = 5'b01000; sweep_exp[0] = 16'h6AA9;
        sweep_psr[1] = 5'b00100; sweep_exp[1] = 16'h5A9A;
        sweep_psr[2] = 5'b10000; sweep_exp[2] = 16'h666A;
        sweep_psr[3] = 5'b00000; sweep_exp[3] = 16'h56AA;

        // ---- reset state
        #12;
        check("rst_out_valid",  {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_result", {16'b0, bus.out_result}, 32'd0);
        check("rst_out_dest",   {28'b0, bus.out_dest}, 32'd0);
        check("rst_out_wb_en",  {31'b0, bus.out_wb_en}, 32'd0);
        check("rst_psr",        {27'b0, bus.psr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("rst_in_ready",   {31'b0, bus.in_ready}, 32'd1);

        // ---- async reset with a pending entry
        load_psr(5'b10101);
        bus.out_ready = 1'b0;
        drive_in(1'b1, 16'h5555, 4'h7, 5'h0, 5'h0);
        step();
        drive_in(1'b0, 16'h0, 4'h0, 5'h0, 5'h0);
        check("pend_out_valid", {31'b0, bus.out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst_psr",       {27'b0, bus.psr}, 32'd0);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        drive_in(1'b1, 16'h1234, 4'h3, 5'h0, 5'h0);
        step();
        drive_in(1'b0, 16'h0, 4'h0, 5'h0, 5'h0);
        check("post_rst_valid",  {31'b0, bus.out_valid}, 32'd1);
        check("post_rst_result", {16'b0, bus.out_result}, 32'h1234);
        check("post_rst_dest",   {28'b0, bus.out_dest}, 32'd3);
        check("post_rst_wb_en",  {31'b0, bus.out_wb_en}, 32'd1);
        step();
        check("post_rst_drained", {31'b0, bus.out_valid}, 32'd0);

        // ---- masked PSR updates
        load_psr(5'b10101);
        check("psr_load", {27'b0, bus.psr}, 32'b10101);
        drive_in(1'b1, 16'h0001, 4'h1, 5'b01010, 5'b00011);
        step();
        drive_in(1'b0, 16'h0, 4'h0, 5'h0, 5'h0);
        check("psr_mask_add", {27'b0, bus.psr}, 32'b10110);
        load_psr(5'b10101);
        drive_in(1'b1, 16'h0002, 4'h1, 5'b01010, 5'b00000);
        step();
        drive_in(1'b0, 16'h0, 4'h0, 5'h0, 5'h0);
        check("psr_mask_zero", {27'b0, bus.psr}, 32'b10101);

        // flags presented without in_valid must not land
        drive_in(1'b0, 16'hDEAD, 4'hF, 5'b01010, 5'b11111);
        step();
        drive_in(1'b0, 16'h0, 4'h0, 5'h0, 5'h0);
        check("xsafe_psr",    {27'b0, bus.psr}, 32'b10101);
        check("xsafe_result", {16'b0, bus.out_result}, 32'h0002);

        // ---- explicit load collides with a full-mask accept
        load_psr(5'b00000);
        bus.psr_wr_en   = 1'b1;
        bus.psr_wr_data = 5'b11111;
        drive_in(1'b1, 16'h0003, 4'h2, 5'b00000, 5'b11111);
        step();
        bus.psr_wr_en = 1'b0;
        drive_in(1'b0, 16'h0, 4'h0, 5'h0, 5'h0);
        check("collision_psr", {27'b0, bus.psr}, 32'b11111);
        step();

        // ---- back-pressure
        bus.out_ready = 1'b0;
        drive_in(1'b1, 16'hAAAA, 4'h4, 5'h0, 5'h0);
        step();
        check("bp_fill_valid",  {31'b0, bus.out_valid}, 32'd1);
        check("bp_fill_result", {16'b0, bus.out_result}, 32'hAAAA);
        drive_in(1'b1, 16'hBBBB, 4'h5, 5'h0, 5'h0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_in_ready_%0d", i), {31'b0, bus.in_ready}, 32'd0);
            step();
            check($sformatf("bp_hold_result_%0d", i), {16'b0, bus.out_result}, 32'hAAAA);
            check($sformatf("bp_hold_dest_%0d", i),   {28'b0, bus.out_dest}, 32'd4);
            check($sformatf("bp_hold_valid_%0d", i),  {31'b0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, bus.in_ready}, 32'd1);
        step();
        drive_in(1'b0, 16'h0, 4'h0, 5'h0, 5'h0);
        check("bp_next_result", {16'b0, bus.out_result}, 32'hBBBB);
        check("bp_next_valid",  {31'b0, bus.out_valid}, 32'd1);
        step();
        check("bp_no_dup", {31'b0, bus.out_valid}, 32'd0);

        // ---- streaming, 1 op/cycle
        for (int i = 0; i < 8; i++) begin
            drive_in(1'b1, 16'h1000 + 16'(i), 4'(i), 5'h0, 5'h0);
            check($sformatf("stream_ready_%0d", i), {31'b0, bus.in_ready}, 32'd1);
            step();
            check($sformatf("stream_valid_%0d", i),  {31'b0, bus.out_valid}, 32'd1);
            check($sformatf("stream_result_%0d", i), {16'b0, bus.out_result}, 32'h1000 + i);
            check($sformatf("stream_dest_%0d", i),   {28'b0, bus.out_dest}, 32'(i));
        end
        drive_in(1'b0, 16'h0, 4'h0, 5'h0, 5'h0);
        step();
        check("stream_done", {31'b0, bus.out_valid}, 32'd0);

        // ---- branch sees pre-update PSR
        load_psr(5'b00000);
        bus.cond_code = 4'h0;
        drive_in(1'b1, 16'h0, 4'h0, 5'b01000, 5'b11100);
        #1;
        check("hazard_pre",  {31'b0, bus.cond_true}, 32'd0);
        step();
        drive_in(1'b0, 16'h0, 4'h0, 5'h0, 5'h0);
        check("hazard_post", {31'b0, bus.cond_true}, 32'd1);

        // ---- condition sweep
        for (int p = 0; p < 4; p++) begin
            load_psr(sweep_psr[p]);
            exp_vec = sweep_exp[p];
            for (int c = 0; c < 16; c++) begin
                bus.cond_code = 4'(c);
                #1;
                check($sformatf("cond_psr%05b_cc%0h", sweep_psr[p], c),
                      {31'b0, bus.cond_true}, {31'b0, exp_vec[c]});
            end
        end

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule : tb_psr_writeback_stage
`default_nettype wire

// File: doc/psr_writeback_stage.md
Name: psr_writeback_stage

Overview:
- Pipeline stage directly downstream of the 16-bit ALU.
- Captures the ALU result and its 5-bit flag vector (bit order C F L Z N, bits 0..4) into a single-entry valid/ready output register.
- Maintains the architectural PSR register with per-instruction flag-update masks.
- Evaluates CR16-style branch condition codes against the committed PSR for the branch/jump unit.

Parameters:
- WIDTH, 16, datapath width of result.
- REGADDR, 4, width of destination register index.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU stage presents a valid operation.
- in_ready  out  1  stage can accept this cycle.
- in_result  in  WIDTH  ALU result.
- in_psr  in  5  ALU-produced flags {N,Z,L,F,C}.
- in_flag_mask  in  5  1 = this flag is updated by the instruction.
- in_dest  in  REGADDR  destination register index.
- in_wb_en  in  1  instruction writes the register file.
- out_valid  out  1  registered entry is valid.
- out_ready  in  1  register-file write port consumes the entry.
- out_result  out  WIDTH  registered result.
- out_dest  out  REGADDR  registered destination.
- out_wb_en  out  1  registered write enable.
- psr_wr_en  in  1  explicit PSR load (LPR instruction).
- psr_wr_data  in  5  value for explicit PSR load.
- psr  out  5  architectural PSR register.
- cond_code  in  4  branch condition selector.
- cond_true  out  1  condition satisfied by current psr (combinational from the psr register).

Behaviour:
- Reset (async, immediate): out_valid=0, out_result=0, out_dest=0, out_wb_en=0, psr=5'b0. in_ready=1 once reset deasserts.
- Handshake:
  - in_ready = !out_valid || out_ready; no combinational path from in_valid to in_ready.
  - Accept when in_valid && in_ready: next edge loads out_result, out_dest and out_wb_en, and sets out_valid=1.
  - Drain when out_valid && out_ready && !accept: next edge clears out_valid. out_result, out_dest and out_wb_en hold their last values.
  - Accept and drain in the same cycle: entry is replaced, out_valid stays 1. Gives full throughput at 1 op/cycle.
  - Back-pressure: out_valid=1 and out_ready=0 holds all out_* stable and drives in_ready=0. Stable outputs are checked every cycle.
- Latency: 1 cycle from accept to out_valid; 1 cycle from accept to psr update.
- PSR update:
  - On accept: psr <= (psr & ~in_flag_mask) | (in_psr & in_flag_mask).
  - Flags are updated on accept, not on drain.
  - in_flag_mask=0: psr unchanged.
- Explicit load: psr_wr_en=1 loads psr <= psr_wr_data regardless of handshake.
  - When it coincides with an accepting masked update in the same cycle, the explicit load wins entirely.
- cond_true is decoded from the psr register (never from in_psr):
  - 0000 EQ: Z=1
  - 0001 NE: Z=0
  - 0010 CS: C=1
  - 0011 CC: C=0
  - 0100 HI: L=1
  - 0101 LS: L=0
  - 0110 GT: N=1
  - 0111 LE: N=0
  - 1000 FS: F=1
  - 1001 FC: F=0
  - 1010 LO: L=0 and Z=0
  - 1011 HS: L=1 or Z=1
  - 1100 LT: N=0 and Z=0
  - 1101 GE: N=1 or Z=1
  - 1110 UC: 1
  - 1111: 0
- Hazard rule: a branch in the same cycle as a flag-setting accept sees the pre-update psr. The controller inserts one cycle between them.
- Reset mid-operation: a pending entry is discarded and out_valid drops asynchronously. No write is issued after reset.
- X-safety: when in_valid=0, in_* are ignored and never reach psr or the out_* registers.

Decomposition:
- Shared package holds:
  - PSR bit indices PSR_C=0, PSR_F=1, PSR_L=2, PSR_Z=3, PSR_N=4.
  - 4-bit condition-code constants COND_EQ..COND_NV.
  - Per-opcode flag-mask constants: ADD=C|F, SUB=C|F|L, CMP=Z|N|L, logic ops=0.
- Sub-module cond_eval: purely combinational psr + cond_code -> cond_true. The branch unit reuses it.

Test Plan:
- Reset with out_valid=1 pending mid-cycle -> out_valid=0 and psr=0 immediately, before the next clk edge; first post-reset accept of result 16'h1234, dest 3 -> out_result=16'h1234, out_dest=3 one cycle later.
- Masked update: psr=5'b10101, in_psr=5'b01010, mask=5'b00011 (ADD) -> psr=5'b10110; same with mask=0 -> psr stays 5'b10101.
- Back-pressure: fill entry with 16'hAAAA, out_ready=0 for 3 cycles while in_valid=1 with 16'hBBBB -> in_ready=0 and out_result=16'hAAAA held all 3 cycles; raise out_ready -> 16'hBBBB appears the next cycle, no loss or duplication.
- Streaming: 8 back-to-back ops with out_ready=1 -> 8 outputs in 8 consecutive cycles, in order, in_ready constantly 1.
- Collision: psr_wr_en=1 with psr_wr_data=5'b11111 in the same cycle as an accept with mask=5'b11111 and in_psr=0 -> psr=5'b11111.
- Condition sweep: for psr in {5'b01000, 5'b00100, 5'b10000, 5'b00000}, all 16 cond_code values -> e.g. psr=5'b01000 gives EQ=1, HS=1, GE=1, LO=0, LT=0, NV=0, UC=1.
